// File: rtl/relu_sched_pkg.sv
// relu_sched_pkg: shared defaults and ReLU semantics
// for the round-robin ReLU scheduler and standalone datapath.
package relu_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int MAX_DATA_W  = 64;

  // Width of a requester index; never narrower than 1 bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operates on a sign-extended sample so any width up to
  // MAX_DATA_W shares one definition; callers truncate back.
  function automatic logic [MAX_DATA_W-1:0] relu_apply(
    input logic [MAX_DATA_W-1:0] data,
    input logic                  en
  );
    return (en && data[MAX_DATA_W-1]) ? '0 : data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting
// at rr_ptr; the pointer itself lives in the caller.
import relu_sched_pkg::*;

module rr_arbiter #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // Scan from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ)
        j = j - NUM_REQ;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    if (enable && grant_valid)
      grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/relu_rr_scheduler.sv
// relu_rr_scheduler: one ReLU datapath shared by NUM_REQ
// lanes, round-robin granted, registered valid/ready output.
import relu_sched_pkg::*;

module relu_rr_scheduler #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]   rr_ptr;
  logic              can_accept;
  logic              arb_en;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_valid;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] relu_out;

  // Output slot is free when empty or draining this edge;
  // ready is forced low while reset is held.
  always_comb begin
    can_accept = !out_valid || out_ready;
    arb_en     = can_accept && reset;
    xfer       = arb_en && grant_valid;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .enable      (arb_en),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Select the granted lane and apply ReLU on its sample.
  always_comb begin
    sel_data = req_data[grant_idx*DATA_W +: DATA_W];
    relu_out = DATA_W'(relu_apply(
      MAX_DATA_W'($signed(sel_data)), relu_en));
  end

  // Output register, handshake and pointer advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= relu_out;
      out_id    <= grant_idx;
      rr_ptr    <= (grant_idx == LAST) ? '0
                 : grant_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_rr_scheduler.sv
// tb_relu_rr_scheduler: scoreboard bench with a cycle
// model of arbitration, ReLU and the output register.
module tb_relu_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           relu_en;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;

  typedef struct {
    int           id;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sbq[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] lane_d[N];
  int           n_id[N];
  int           xg;

  relu_rr_scheduler #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .ID_W    (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_relu(
    input logic [W-1:0] d, input logic en);
    return (en && d[W-1]) ? '0 : d;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_ptr   = 0;
    sbq.delete();
  endtask

  // One cycle: check at negedge, update model, cross posedge.
  task automatic step(output int g);
    logic [N-1:0] er;
    bit           can;
    exp_t         e;
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = lane_d[i];
    @(negedge clk);
    can = !m_valid || out_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && req_valid[j])
        g = j;
    end
    er = '0;
    if (can && g >= 0)
      er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        chk("out_data", 32'(out_data), 32'(sbq[0].d));
        chk("out_id", 32'(out_id), 32'(sbq[0].id));
        if (out_ready) begin
          n_id[out_id]++;
          void'(sbq.pop_front());
        end
      end
    end
    if (can && g >= 0) begin
      e.id = g;
      e.d  = ref_relu(lane_d[g], relu_en);
      sbq.push_back(e);
      m_valid = 1'b1;
      m_ptr   = (g == N - 1) ? 0 : g + 1;
    end else begin
      if (m_valid && out_ready)
        m_valid = 1'b0;
      g = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] vals [4];
    req_valid = '0;
    req_data  = '0;
    relu_en   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      lane_d[i] = '0;
      n_id[i]   = 0;
    end
    model_clear();

    // Reset held, then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    repeat (10) step(xg);
    chk("idle_id", 32'(out_id), 32'd0);

    // Single requester, ReLU on
    vals[0] = 8'h05; vals[1] = 8'h80;
    vals[2] = 8'hFF; vals[3] = 8'h7F;
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      lane_d[2] = vals[i];
      step(xg);
    end
    req_valid = '0;
    step(xg);

    // All valid, fair share
    apply_reset();
    for (int i = 0; i < N; i++) n_id[i] = 0;
    req_valid = 4'hF;
    repeat (100) begin
      for (int i = 0; i < N; i++)
        lane_d[i] = W'($urandom);
      step(xg);
    end
    req_valid = '0;
    step(xg);
    for (int i = 0; i < N; i++)
      chk($sformatf("share_%0d", i), 32'(n_id[i]), 32'd25);

    // Backpressure on a held negative sample
    req_valid = 4'b0010;
    lane_d[1] = 8'h90;
    step(xg);
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (5) begin
      step(xg);
      chk("bp_data", 32'(out_data), 32'h00);
      chk("bp_id", 32'(out_id), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_next", 32'(req_ready), 32'b0100);
    step(xg);
    req_valid = '0;
    step(xg);

    // Bypass, relu_en toggled while stalled
    relu_en = 1'b0;
    req_valid = 4'b1000;
    lane_d[3] = 8'hC3;
    step(xg);
    req_valid = '0;
    out_ready = 1'b0;
    step(xg);
    relu_en = 1'b1;
    repeat (3) step(xg);
    chk("bypass_hold", 32'(out_data), 32'hC3);
    out_ready = 1'b1;
    step(xg);

    // Sparse contention from rr_ptr=3
    req_valid = 4'b0100;
    step(xg);
    req_valid = '0;
    step(xg);
    lane_d[1] = 8'h10;
    lane_d[3] = 8'h30;
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      out_ready = (c % 2 == 0);
      step(xg);
      if (xg >= 0)
        lane_d[xg] = lane_d[xg] + 8'd1;
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (2) step(xg);
    chk("sparse_drained", 32'(sbq.size()), 32'd0);

    // Async reset while holding a result
    req_valid = 4'b0001;
    lane_d[0] = 8'h42;
    step(xg);
    out_ready = 1'b0;
    req_valid = 4'hF;
    step(xg);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    model_clear();
    req_valid = '0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("rst_restart", 32'(req_ready), 32'b0001);
    step(xg);
    req_valid = '0;
    step(xg);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
